// File: rtl/next_line_prefetcher.sv
// Next-line prefetch engine: turns demand misses into reads DISTANCE lines ahead
// and holds one fetched line for the cache to install or drop.
module next_line_prefetcher #(
    parameter int s_offset   = 5,
    parameter int DISTANCE   = 1,
    parameter int CROSS_PAGE = 0,
    localparam int DATA_W    = 8 << s_offset
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    input  logic [31:0]       miss_address,
    input  logic              demand_busy,
    input  logic              fill_valid,
    input  logic [31:0]       fill_address,
    output logic              pf_pmem_read,
    output logic [31:0]       pf_pmem_address,
    input  logic              pf_pmem_resp,
    input  logic [DATA_W-1:0] pf_pmem_rdata,
    output logic              prefetch_ready,
    output logic [31:0]       pf_cline_address,
    output logic [DATA_W-1:0] prefetch_rdata,
    input  logic              pf_accept,
    input  logic              pf_drop
);

    localparam logic [31:0] LINE_MASK = ~((32'd1 << s_offset) - 32'd1);
    localparam logic [32:0] STEP      = 33'(DISTANCE) << s_offset;

    typedef enum logic [1:0] {IDLE, WAIT_ARB, FETCH, HOLD} state_t;

    state_t      state;
    logic        pending_valid;
    logic [31:0] pending_addr;
    logic        kill;

    logic [32:0] sum;
    logic [31:0] target;
    logic [31:0] fill_line;
    logic        carry;
    logic        page_ok;
    logic        active;
    logic        dup;
    logic        trig_ok;
    logic        snoop_active;
    logic        snoop_pending;

    // The 33-bit sum exposes the carry out of the line-number add.
    always_comb begin
        sum           = {1'b0, miss_address & LINE_MASK} + STEP;
        target        = sum[31:0];
        carry         = sum[32];
        page_ok       = (CROSS_PAGE != 0) || (target[31:12] == miss_address[31:12]);
        active        = (state != IDLE);
        dup           = (active && (target == pf_pmem_address)) ||
                        (pending_valid && (target == pending_addr));
        trig_ok       = miss_valid && !carry && page_ok && !dup;
        fill_line     = fill_address & LINE_MASK;
        snoop_active  = fill_valid && active && (fill_line == pf_pmem_address);
        snoop_pending = fill_valid && pending_valid && (fill_line == pending_addr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            pending_valid    <= 1'b0;
            pending_addr     <= '0;
            kill             <= 1'b0;
            pf_pmem_read     <= 1'b0;
            pf_pmem_address  <= '0;
            prefetch_ready   <= 1'b0;
            pf_cline_address <= '0;
            prefetch_rdata   <= '0;
        end else begin
            // A busy engine parks the newest trigger; a fill of that line cancels it.
            if (trig_ok && active) begin
                pending_valid <= 1'b1;
                pending_addr  <= target;
            end else if (snoop_pending) begin
                pending_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (trig_ok) begin
                        pf_pmem_address <= target;
                        state           <= WAIT_ARB;
                    end else if (pending_valid && !snoop_pending) begin
                        pf_pmem_address <= pending_addr;
                        pending_valid   <= 1'b0;
                        state           <= WAIT_ARB;
                    end
                end
                WAIT_ARB: begin
                    if (snoop_active) begin
                        state <= IDLE;
                    end else if (!demand_busy) begin
                        pf_pmem_read <= 1'b1;
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    // The burst always completes; a snooped line is only discarded.
                    if (pf_pmem_resp) begin
                        pf_pmem_read <= 1'b0;
                        kill         <= 1'b0;
                        if (kill || snoop_active) begin
                            state <= IDLE;
                        end else begin
                            prefetch_rdata   <= pf_pmem_rdata;
                            pf_cline_address <= pf_pmem_address;
                            prefetch_ready   <= 1'b1;
                            state            <= HOLD;
                        end
                    end else if (snoop_active) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (pf_accept || pf_drop || snoop_active) begin
                        prefetch_ready <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_next_line_prefetcher.sv
// Directed bench for next_line_prefetcher: stimulus queues expected reads and lines,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_next_line_prefetcher;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_valid;
    logic [31:0]  miss_address;
    logic         demand_busy;
    logic         fill_valid;
    logic [31:0]  fill_address;
    logic         pf_pmem_read;
    logic [31:0]  pf_pmem_address;
    logic         pf_pmem_resp;
    logic [255:0] pf_pmem_rdata;
    logic         prefetch_ready;
    logic [31:0]  pf_cline_address;
    logic [255:0] prefetch_rdata;
    logic         pf_accept;
    logic         pf_drop;

    logic         x_miss_valid;
    logic [31:0]  x_miss_address;
    logic         x_resp;
    logic         x_accept;
    logic         x_read;
    logic [31:0]  x_address;
    logic         x_ready;
    logic [31:0]  x_cline;
    logic [255:0] x_rdata;

    next_line_prefetcher #(.s_offset(5), .DISTANCE(1), .CROSS_PAGE(0)) dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_address(miss_address),
        .demand_busy(demand_busy),
        .fill_valid(fill_valid), .fill_address(fill_address),
        .pf_pmem_read(pf_pmem_read), .pf_pmem_address(pf_pmem_address),
        .pf_pmem_resp(pf_pmem_resp), .pf_pmem_rdata(pf_pmem_rdata),
        .prefetch_ready(prefetch_ready), .pf_cline_address(pf_cline_address),
        .prefetch_rdata(prefetch_rdata),
        .pf_accept(pf_accept), .pf_drop(pf_drop)
    );

    next_line_prefetcher #(.s_offset(5), .DISTANCE(1), .CROSS_PAGE(1)) dut_x (
        .clk(clk), .rst(rst),
        .miss_valid(x_miss_valid), .miss_address(x_miss_address),
        .demand_busy(1'b0),
        .fill_valid(1'b0), .fill_address(32'h0),
        .pf_pmem_read(x_read), .pf_pmem_address(x_address),
        .pf_pmem_resp(x_resp), .pf_pmem_rdata(pf_pmem_rdata),
        .prefetch_ready(x_ready), .pf_cline_address(x_cline),
        .prefetch_rdata(x_rdata),
        .pf_accept(x_accept), .pf_drop(1'b0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] data;
        int           cyc;
    } exp_t;

    exp_t rd_q[$];
    exp_t rdy_q[$];
    exp_t xrd_q[$];
    int   fall_q[$];

    int checks = 0;
    int failures = 0;

    function automatic void chk(string name, logic [255:0] act, logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void push_rd(logic [31:0] a, int c);
        exp_t e;
        e.addr = a; e.data = '0; e.cyc = c;
        rd_q.push_back(e);
    endfunction

    function automatic void push_xrd(logic [31:0] a, int c);
        exp_t e;
        e.addr = a; e.data = '0; e.cyc = c;
        xrd_q.push_back(e);
    endfunction

    function automatic void push_rdy(logic [31:0] a, logic [255:0] d, int c);
        exp_t e;
        e.addr = a; e.data = d; e.cyc = c;
        rdy_q.push_back(e);
    endfunction

    // Monitor
    logic        prev_rd = 1'b0;
    logic        prev_rdy = 1'b0;
    logic        prev_xrd = 1'b0;
    logic [31:0] cur_rd;
    exp_t        cur_line;
    exp_t        mon_e;
    int          mon_fc;

    always @(negedge clk) begin
        if (pf_pmem_read && !prev_rd) begin
            if (rd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd_unexpected actual=%0h required=no_read", pf_pmem_address);
            end else begin
                mon_e = rd_q.pop_front();
                chk("rd_addr", pf_pmem_address, mon_e.addr);
                chk("rd_cycle", cyc, mon_e.cyc);
            end
            cur_rd = pf_pmem_address;
        end else if (pf_pmem_read) begin
            chk("rd_addr_stable", pf_pmem_address, cur_rd);
        end

        if (prefetch_ready && !prev_rdy) begin
            if (rdy_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL ready_unexpected actual=%0h required=no_line", pf_cline_address);
            end else begin
                mon_e = rdy_q.pop_front();
                chk("ready_addr", pf_cline_address, mon_e.addr);
                chk("ready_data", prefetch_rdata, mon_e.data);
                chk("ready_cycle", cyc, mon_e.cyc);
                cur_line = mon_e;
            end
        end else if (prefetch_ready) begin
            chk("hold_addr_stable", pf_cline_address, cur_line.addr);
            chk("hold_data_stable", prefetch_rdata, cur_line.data);
        end else if (prev_rdy) begin
            if (fall_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL ready_fall_unexpected actual=%0d required=no_fall", cyc);
            end else begin
                mon_fc = fall_q.pop_front();
                chk("ready_fall_cycle", cyc, mon_fc);
            end
        end

        if (x_read && !prev_xrd) begin
            if (xrd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL xrd_unexpected actual=%0h required=no_read", x_address);
            end else begin
                mon_e = xrd_q.pop_front();
                chk("xrd_addr", x_address, mon_e.addr);
                chk("xrd_cycle", cyc, mon_e.cyc);
            end
        end

        prev_rd  = pf_pmem_read;
        prev_rdy = prefetch_ready;
        prev_xrd = x_read;
    end

    // Stimulus
    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic miss(logic [31:0] a);
        miss_address = a; miss_valid = 1'b1;
        step(1);
        miss_valid = 1'b0;
    endtask

    task automatic xmiss(logic [31:0] a);
        x_miss_address = a; x_miss_valid = 1'b1;
        step(1);
        x_miss_valid = 1'b0;
    endtask

    task automatic wait_rd();
        int n = 0;
        while (!pf_pmem_read && n < 50) begin
            step(1);
            n++;
        end
        if (!pf_pmem_read) begin
            checks++; failures++;
            $display("FAIL rd_timeout actual=0 required=1");
        end
    endtask

    task automatic resp(logic [31:0] a, logic [255:0] d, bit expect_line);
        if (expect_line) push_rdy(a, d, cyc + 1);
        pf_pmem_rdata = d; pf_pmem_resp = 1'b1;
        step(1);
        pf_pmem_resp = 1'b0;
    endtask

    task automatic accept();
        fall_q.push_back(cyc + 1);
        pf_accept = 1'b1;
        step(1);
        pf_accept = 1'b0;
    endtask

    task automatic drop();
        fall_q.push_back(cyc + 1);
        pf_drop = 1'b1;
        step(1);
        pf_drop = 1'b0;
    endtask

    task automatic fill(logic [31:0] a, bit expect_fall);
        if (expect_fall) fall_q.push_back(cyc + 1);
        fill_address = a; fill_valid = 1'b1;
        step(1);
        fill_valid = 1'b0;
    endtask

    int c0;

    initial begin
        rst = 1'b0;
        miss_valid = 1'b0; miss_address = '0; demand_busy = 1'b0;
        fill_valid = 1'b0; fill_address = '0;
        pf_pmem_resp = 1'b0; pf_pmem_rdata = '0;
        pf_accept = 1'b0; pf_drop = 1'b0;
        x_miss_valid = 1'b0; x_miss_address = '0; x_resp = 1'b0; x_accept = 1'b0;

        step(3);
        chk("reset_read", pf_pmem_read, 0);
        chk("reset_addr", pf_pmem_address, 0);
        chk("reset_ready", prefetch_ready, 0);
        chk("reset_cline", pf_cline_address, 0);
        chk("reset_rdata", prefetch_rdata, 0);
        rst = 1'b1;
        step(2);

        // Basic fetch of the next line
        push_rd(32'h0000_1060, cyc + 2);
        miss(32'h0000_1040);
        wait_rd();
        step(2);
        resp(32'h0000_1060, {8{32'hA5A5_0001}}, 1'b1);
        step(3);
        accept();
        step(3);

        // Page limit and wrap
        miss(32'h0000_1FE0);
        step(5);
        miss(32'hFFFF_FFE0);
        step(5);
        push_xrd(32'h0000_2000, cyc + 2);
        xmiss(32'h0000_1FE0);
        step(2);
        pf_pmem_rdata = {8{32'h0BAD_2000}};
        x_resp = 1'b1;
        step(1);
        x_resp = 1'b0;
        chk("x_ready", x_ready, 1);
        chk("x_cline", x_cline, 32'h0000_2000);
        x_accept = 1'b1;
        step(1);
        x_accept = 1'b0;
        step(2);
        xmiss(32'hFFFF_FFE0);
        step(6);

        // Arbitration hold-off, then pending overwrite
        c0 = cyc;
        demand_busy = 1'b1;
        miss(32'h0000_0100);
        step(9);
        push_rd(32'h0000_0120, c0 + 11);
        demand_busy = 1'b0;
        wait_rd();
        step(2);
        resp(32'h0000_0120, {8{32'hC0DE_0120}}, 1'b1);
        miss(32'h0000_0200);
        miss(32'h0000_0300);
        step(2);
        push_rd(32'h0000_0320, cyc + 3);
        accept();
        wait_rd();
        step(1);
        resp(32'h0000_0320, {8{32'hC0DE_0320}}, 1'b1);
        step(2);
        accept();
        step(5);

        // Snoop kill during fetch, snoop during hold
        c0 = cyc;
        push_rd(32'h0000_0120, c0 + 2);
        miss(32'h0000_0100);
        step(2);
        fill(32'h0000_0120, 1'b0);
        step(1);
        resp(32'h0000_0120, {8{32'hDEAD_0120}}, 1'b0);
        step(1);
        push_rd(32'h0000_0420, cyc + 2);
        miss(32'h0000_0400);
        wait_rd();
        step(1);
        resp(32'h0000_0420, {8{32'h1234_0420}}, 1'b1);
        step(2);
        fill(32'h0000_0420, 1'b1);
        step(4);

        // Dedupe against the active target, then drop
        push_rd(32'h0000_0120, cyc + 2);
        miss(32'h0000_0100);
        step(1);
        miss(32'h0000_0100);
        step(1);
        miss(32'h0000_0100);
        step(1);
        resp(32'h0000_0120, {8{32'h5555_0120}}, 1'b1);
        step(2);
        drop();
        step(10);

        // Asynchronous reset in the middle of a fetch
        push_rd(32'h0000_0120, cyc + 2);
        miss(32'h0000_0100);
        wait_rd();
        step(1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_read", pf_pmem_read, 0);
        chk("async_rst_ready", prefetch_ready, 0);
        chk("async_rst_addr", pf_pmem_address, 0);
        step(2);
        rst = 1'b1;
        step(1);
        push_rd(32'h0000_0060, cyc + 2);
        miss(32'h0000_0040);
        wait_rd();
        step(1);
        resp(32'h0000_0060, {8{32'h7777_0060}}, 1'b1);
        step(1);
        accept();
        step(5);

        chk("rd_q_drained", rd_q.size(), 0);
        chk("rdy_q_drained", rdy_q.size(), 0);
        chk("fall_q_drained", fall_q.size(), 0);
        chk("xrd_q_drained", xrd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/next_line_prefetcher.md
Name: next_line_prefetcher

Overview:
- Prefetch engine that produces the lines consumed by the prefetch cache datapath.
- Watches demand-miss addresses from the L1 controller, computes the line DISTANCE lines ahead, and reads it from physical memory through the cacheline adapter port.
- Holds the fetched 256-bit line and offers it to the cache on prefetch_ready / pf_cline_address / prefetch_rdata until the cache installs or drops it.

Parameters:
- s_offset, 5: line offset bits; line = 2**s_offset bytes = 256 bits.
- DISTANCE, 1: lines ahead of the miss to prefetch, range 1..7.
- CROSS_PAGE, 0: 0 drops any target whose bits [31:12] differ from the miss address; 1 allows page crossing.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-low.
- miss_valid  in  1  one-cycle pulse: cache started a demand miss.
- miss_address  in  32  address of that demand miss.
- demand_busy  in  1  demand traffic owns the pmem port; the prefetcher must not start a read.
- fill_valid  in  1  one-cycle pulse: cache finished a demand fill.
- fill_address  in  32  line address of that fill.
- pf_pmem_read  out  1  read request to the cacheline adapter.
- pf_pmem_address  out  32  line-aligned read address.
- pf_pmem_resp  in  1  one-cycle pulse: read data valid.
- pf_pmem_rdata  in  256  read data.
- prefetch_ready  out  1  buffered line available to the cache.
- pf_cline_address  out  32  line address of the buffered line.
- prefetch_rdata  out  256  buffered line data.
- pf_accept  in  1  cache installed the buffered line.
- pf_drop  in  1  cache declined the line (already resident).

Behaviour:
- Reset values (all outputs): pf_pmem_read=0, pf_pmem_address=0, prefetch_ready=0, pf_cline_address=0, prefetch_rdata=0. Internal state: FSM=IDLE, pending_valid=0, kill=0.
- Target computation:
  - target = {(miss_address[31:s_offset] + DISTANCE), s_offset'b0}.
  - The trigger is discarded if the 27-bit add carries out (wrap past 0xFFFFFFE0).
  - The trigger is discarded if CROSS_PAGE=0 and target[31:12] != miss_address[31:12].
- Dedupe: a trigger is discarded if its target equals the active target (WAIT_ARB/FETCH/HOLD) or the pending target.
- Pending slot: one entry. A trigger accepted while the FSM is not IDLE is written to the pending slot. A newer trigger overwrites an older pending one.
- IDLE:
  - On an accepted trigger (or pending_valid), latch target into pf_pmem_address and go to WAIT_ARB next cycle.
  - A trigger has priority over pending; pending is then overwritten by nothing and stays.
- WAIT_ARB:
  - While demand_busy=1, stay.
  - When demand_busy=0, assert pf_pmem_read next cycle and go to FETCH.
- FETCH:
  - pf_pmem_read stays high, with a stable address, until pf_pmem_resp.
  - demand_busy is ignored once the read has been asserted; no mid-burst abort.
  - On pf_pmem_resp with kill=0: register the data and address; prefetch_ready=1 next cycle; go to HOLD.
  - On pf_pmem_resp with kill=1: discard, clear kill, go to IDLE.
  - pf_pmem_read drops the cycle after pf_pmem_resp.
- HOLD:
  - prefetch_ready, pf_cline_address and prefetch_rdata are stable until pf_accept or pf_drop is sampled high.
  - prefetch_ready falls the next cycle and the FSM goes to IDLE.
  - pf_accept and pf_drop high together are treated as pf_accept.
- Snoop (fill_valid with fill_address line == active target):
  - In WAIT_ARB: return to IDLE, no read issued.
  - In FETCH: set kill.
  - In HOLD: prefetch_ready falls next cycle, go to IDLE.
  - A match against the pending target clears pending_valid.
  - A snoop and an accept in the same cycle in HOLD are treated as accept.
- Simultaneous trigger and state exit: the trigger goes to pending and is serviced from IDLE the following cycle. A pending entry is never lost when the FSM exits.
- Minimum latencies:
  - miss_valid at cycle N in IDLE with demand_busy=0: WAIT_ARB at N+1, pf_pmem_read=1 at N+2.
  - pf_pmem_resp at M: prefetch_ready=1 at M+1.
- Reset mid-operation: all state clears asynchronously and pf_pmem_read drops immediately. The adapter shares the same reset, so no orphaned burst survives.

Test Plan:
- Basic fetch: miss_address=0x00001040, demand_busy=0 -> pf_pmem_read at N+2 with pf_pmem_address=0x00001060; resp with data D -> prefetch_ready=1, pf_cline_address=0x00001060, prefetch_rdata=D until pf_accept, then 0.
- Page boundary: miss 0x00001FE0, CROSS_PAGE=0 -> no pf_pmem_read. Same stimulus with CROSS_PAGE=1 -> read of 0x00002000. Miss 0xFFFFFFE0 -> no read.
- Arbitration and pending: demand_busy=1 for 10 cycles after trigger 0x100 -> no read until busy falls. Triggers 0x200 then 0x300 while HOLD -> after accept, the next read is 0x320 only; 0x220 is never fetched.
- Snoop kill: fill_address=0x120 during FETCH of 0x120 -> resp discarded, prefetch_ready stays 0, FSM back to IDLE. Snoop during HOLD -> prefetch_ready falls next cycle.
- Dedupe: trigger 0x100 twice while FETCH 0x120 -> exactly one read of 0x120 and pending stays empty. pf_drop in HOLD -> ready falls, no reissue.
- Async reset: assert rst low mid-FETCH between clock edges -> pf_pmem_read and prefetch_ready are 0 immediately. After release, new trigger 0x40 -> read 0x60 with normal latency.
